// File: rtl/fxp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fxp_pkg
//  Description : Shared fixed-point helpers for the requantization datapath:
//                signed saturation limits and the shift-amount helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package fxp_pkg;

    // Largest value representable in a signed two's complement field of 'width' bits.
    function automatic logic signed [63:0] fxp_sat_max(input int width);
        return (64'sd1 <<< (width - 1)) - 64'sd1;
    endfunction

    // Smallest value representable in a signed two's complement field of 'width' bits.
    function automatic logic signed [63:0] fxp_sat_min(input int width);
        return -(64'sd1 <<< (width - 1));
    endfunction

    // Right-shift amount that moves the binary point from in_frac to out_frac.
    function automatic int fxp_shift(input int in_frac, input int out_frac);
        return in_frac - out_frac;
    endfunction

endpackage : fxp_pkg
`default_nettype wire

// File: rtl/fxp_sat.sv
`default_nettype none
// ============================================================================
//  Module      : fxp_sat
//  Description : Combinational signed clip from IN_W bits to OUT_W bits with
//                a flag that reports when clipping occurred.
//  Revision    : 1.0 - initial release
//  Ports       : val_i  [IN_W]  signed value to be clipped
//                data_o [OUT_W] clipped signed value
//                sat_o  [1]     1 when val_i lay outside the OUT_W range
// ============================================================================
module fxp_sat
    import fxp_pkg::*;
#(
    parameter int IN_W  = 17,
    parameter int OUT_W = 8
) (
    input  logic signed [IN_W-1:0]  val_i,
    output logic        [OUT_W-1:0] data_o,
    output logic                    sat_o
);

    // Limits computed at full precision, then narrowed to the compare width.
    localparam logic signed [63:0]     c_MAX_W = fxp_sat_max(OUT_W);
    localparam logic signed [63:0]     c_MIN_W = fxp_sat_min(OUT_W);
    localparam logic signed [IN_W-1:0] c_MAX   = c_MAX_W[IN_W-1:0];
    localparam logic signed [IN_W-1:0] c_MIN   = c_MIN_W[IN_W-1:0];

    always_comb begin
        data_o = val_i[OUT_W-1:0];
        sat_o  = 1'b0;
        if (val_i > c_MAX) begin
            data_o = c_MAX[OUT_W-1:0];
            sat_o  = 1'b1;
        end else if (val_i < c_MIN) begin
            data_o = c_MIN[OUT_W-1:0];
            sat_o  = 1'b1;
        end
    end

endmodule : fxp_sat
`default_nettype wire

// File: rtl/fxp_requant_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : fxp_requant_pipe
//  Description : Two-stage elastic pipeline requantizing signed fixed-point
//                samples Q(IN_WIDTH,IN_FRAC) -> Q(OUT_WIDTH,OUT_FRAC).
//                Stage 1: optional round-half-up + arithmetic right shift.
//                Stage 2: saturation. Valid/ready handshake on both sides and
//                a sticky-at-max counter of saturated output transfers.
//  Revision    : 1.0 - initial release
//  Ports       : clk, rst            clock / synchronous active-high reset
//                in_data/in_round    input sample and its rounding mode
//                in_valid/in_ready   input handshake
//                out_data/out_sat    requantized sample and clip flag
//                out_valid/out_ready output handshake
//                sat_clr/sat_cnt     counter clear / saturation event count
// ============================================================================
module fxp_requant_pipe
    import fxp_pkg::*;
#(
    parameter int IN_WIDTH  = 16,
    parameter int IN_FRAC   = 8,
    parameter int OUT_WIDTH = 8,
    parameter int OUT_FRAC  = 4,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [IN_WIDTH-1:0]  in_data,
    input  logic                 in_round,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic                 out_sat,
    output logic                 out_valid,
    input  logic                 out_ready,
    input  logic                 sat_clr,
    output logic [CNT_WIDTH-1:0] sat_cnt
);

    localparam int c_SHIFT = fxp_shift(IN_FRAC, OUT_FRAC);

    if (OUT_FRAC > IN_FRAC) begin : g_bad_frac
        $error("fxp_requant_pipe: OUT_FRAC must not exceed IN_FRAC");
    end
    if (OUT_WIDTH > IN_WIDTH) begin : g_bad_width
        $error("fxp_requant_pipe: OUT_WIDTH must not exceed IN_WIDTH");
    end

    // ---------------- handshake ----------------
    logic r_s1_valid_q, r_s2_valid_q;
    logic w_s1_adv, w_s2_adv;

    assign w_s2_adv = !r_s2_valid_q || out_ready;
    assign w_s1_adv = !r_s1_valid_q || w_s2_adv;
    assign in_ready = w_s1_adv;

    // ---------------- stage 1: round + shift ----------------
    // One guard bit keeps the rounding add from overflowing at the positive limit.
    logic signed [IN_WIDTH:0] w_ext, w_rnd, w_s1_val_d, r_s1_val_q;

    assign w_ext = {in_data[IN_WIDTH-1], in_data};

    if (c_SHIFT > 0) begin : g_round
        localparam logic signed [IN_WIDTH:0] c_HALF = {{IN_WIDTH{1'b0}}, 1'b1} << (c_SHIFT - 1);
        assign w_rnd = in_round ? (w_ext + c_HALF) : w_ext;
    end else begin : g_no_round
        // Nothing is discarded by the shift, so rounding has nothing to do.
        logic w_unused_round;
        assign w_unused_round = in_round;
        assign w_rnd          = w_ext;
    end

    assign w_s1_val_d = w_rnd >>> c_SHIFT;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid_q <= 1'b0;
            r_s1_val_q   <= '0;
        end else if (w_s1_adv) begin
            r_s1_valid_q <= in_valid;
            if (in_valid) begin
                r_s1_val_q <= w_s1_val_d;
            end
        end
    end

    // ---------------- stage 2: saturate ----------------
    logic [OUT_WIDTH-1:0] w_s2_data_d, r_s2_data_q;
    logic                 w_s2_sat_d, r_s2_sat_q;

    fxp_sat #(
        .IN_W  (IN_WIDTH + 1),
        .OUT_W (OUT_WIDTH)
    ) u_sat (
        .val_i  (r_s1_val_q),
        .data_o (w_s2_data_d),
        .sat_o  (w_s2_sat_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_valid_q <= 1'b0;
            r_s2_data_q  <= '0;
            r_s2_sat_q   <= 1'b0;
        end else if (w_s2_adv) begin
            r_s2_valid_q <= r_s1_valid_q;
            if (r_s1_valid_q) begin
                r_s2_data_q <= w_s2_data_d;
                r_s2_sat_q  <= w_s2_sat_d;
            end
        end
    end

    assign out_valid = r_s2_valid_q;
    assign out_data  = r_s2_data_q;
    assign out_sat   = r_s2_sat_q;

    // ---------------- saturation event counter ----------------
    logic [CNT_WIDTH-1:0] w_sat_cnt_d, r_sat_cnt_q;

    always_comb begin
        w_sat_cnt_d = r_sat_cnt_q;
        if (sat_clr) begin
            w_sat_cnt_d = '0;
        end else if (r_s2_valid_q && out_ready && r_s2_sat_q
                     && (r_sat_cnt_q != {CNT_WIDTH{1'b1}})) begin
            w_sat_cnt_d = r_sat_cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sat_cnt_q <= '0;
        end else begin
            r_sat_cnt_q <= w_sat_cnt_d;
        end
    end

    assign sat_cnt = r_sat_cnt_q;

endmodule : fxp_requant_pipe
`default_nettype wire
